// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel between I$ and D$.
// Round-robin grant, held from AR handshake to rlast; checks burst length.
module axi_read_arbiter #(
  parameter logic [3:0] ID_I   = 4'd0,
  parameter logic [3:0] ID_D   = 4'd1,
  parameter logic [2:0] SIZE_I = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        burst_err
);

  typedef enum logic [2:0] {
    IDLE, ADDR_I, ADDR_D, DATA_I, DATA_D
  } state_e;

  state_e     state_q, state_d;
  logic       last_d_q, last_d_d;
  logic [7:0] len_q, len_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       burst_err_q, burst_err_d;
  logic       beat;
  logic       rid_unused;

  assign rid_unused = ^rid;
  assign beat = rvalid && rready;
  assign burst_err = burst_err_q;

  // grant arbitration, address phase exit and beat counting
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    unique case (state_q)
      IDLE: begin
        if (d_arvalid && (!i_arvalid || !last_d_q)) begin
          state_d  = ADDR_D;
          last_d_d = 1'b1;
        end else if (i_arvalid) begin
          state_d  = ADDR_I;
          last_d_d = 1'b0;
        end
      end
      ADDR_I: begin
        if (!i_arvalid) begin
          state_d = IDLE;
        end else if (arready) begin
          state_d    = DATA_I;
          len_d      = i_arlen;
          beat_cnt_d = 8'd0;
        end
      end
      ADDR_D: begin
        if (!d_arvalid) begin
          state_d = IDLE;
        end else if (arready) begin
          state_d    = DATA_D;
          len_d      = d_arlen;
          beat_cnt_d = 8'd0;
        end
      end
      DATA_I, DATA_D: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (rlast) begin
            state_d = IDLE;
            if (beat_cnt_q != len_q) burst_err_d = 1'b1;
          end else if (beat_cnt_q == len_q) begin
            burst_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // route AR payload and R beats to/from the current owner
  always_comb begin
    arvalid   = 1'b0;
    araddr    = i_araddr;
    arlen     = i_arlen;
    arsize    = SIZE_I;
    arid      = ID_I;
    arburst   = 2'b01;
    i_arready = 1'b0;
    d_arready = 1'b0;
    rready    = 1'b0;
    i_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rvalid  = 1'b0;
    d_rlast   = 1'b0;
    i_rdata   = rdata;
    d_rdata   = rdata;
    unique case (state_q)
      ADDR_I: begin
        arvalid   = i_arvalid;
        i_arready = arready;
      end
      ADDR_D: begin
        arvalid   = d_arvalid;
        araddr    = d_araddr;
        arlen     = d_arlen;
        arsize    = d_arsize;
        arid      = ID_D;
        d_arready = arready;
      end
      DATA_I: begin
        rready   = i_rready;
        i_rvalid = rvalid;
        i_rlast  = rlast;
      end
      DATA_D: begin
        rready   = d_rready;
        d_rvalid = rvalid;
        d_rlast  = rlast;
      end
      default: ;
    endcase
  end

  // state, round-robin history, burst length tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      len_q       <= 8'd0;
      beat_cnt_q  <= 8'd0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed bursts against a transaction-level model
// of the I/D read arbiter, plus hand-pinned grant order and error checks.
module tb_axi_read_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic        i_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic        i_rlast;
  logic        i_rvalid;
  logic        i_rready;
  logic [31:0] d_araddr;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic        d_arvalid;
  logic        d_arready;
  logic [31:0] d_rdata;
  logic        d_rlast;
  logic        d_rvalid;
  logic        d_rready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        burst_err;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata),
    .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .burst_err(burst_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int ar_stall = 0;
  int ar_wait = 0;
  int bad_last = -1;
  bit r_gap_en = 0;
  bit i_rr_toggle = 0;
  bit s_busy = 0;
  int s_gap = 0;
  int s_beat = 0;
  logic [7:0] s_len = 8'd0;

  int i_beats = 0;
  int d_beats = 0;
  int n_last = 0;
  int av_edges = 0;
  int ar_log[$];
  int last_rlast_cyc = 0;
  int last_ar_cyc = 0;

  // transaction model: owner 0 none, 1 I, 2 D
  int m_owner = 0;
  bit m_addr = 0;
  bit m_last_d = 0;
  bit m_err = 0;
  int m_total = 0;
  int m_got = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner  <= 0;
      m_addr   <= 0;
      m_last_d <= 0;
      m_err    <= 0;
    end else if (m_owner == 0) begin
      if (d_arvalid && !(i_arvalid && m_last_d)) begin
        m_owner <= 2; m_addr <= 1; m_last_d <= 1;
      end else if (i_arvalid) begin
        m_owner <= 1; m_addr <= 1; m_last_d <= 0;
      end
    end else if (m_addr) begin
      if (!(m_owner == 1 ? i_arvalid : d_arvalid)) begin
        m_owner <= 0;
      end else if (arready) begin
        m_addr  <= 0;
        m_got   <= 0;
        m_total <= 1 + int'(m_owner == 1 ? i_arlen : d_arlen);
      end
    end else if (rvalid && (m_owner == 1 ? i_rready : d_rready)) begin
      m_got <= m_got + 1;
      if (rlast) begin
        m_owner <= 0;
        if (m_got + 1 != m_total) m_err <= 1;
      end else if (m_got + 1 == m_total) begin
        m_err <= 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    bit oi, od, ad, dt, eav;
    oi  = (m_owner == 1);
    od  = (m_owner == 2);
    ad  = (m_owner != 0) && m_addr;
    dt  = (m_owner != 0) && !m_addr;
    eav = ad && (oi ? i_arvalid : d_arvalid);
    chk("arvalid", arvalid, eav);
    chk("i_arready", i_arready, ad && oi && arready);
    chk("d_arready", d_arready, ad && od && arready);
    chk("rready", rready, dt && (oi ? i_rready : d_rready));
    chk("i_rvalid", i_rvalid, dt && oi && rvalid);
    chk("i_rlast", i_rlast, dt && oi && rlast);
    chk("d_rvalid", d_rvalid, dt && od && rvalid);
    chk("d_rlast", d_rlast, dt && od && rlast);
    chk("i_rdata", i_rdata, rdata);
    chk("d_rdata", d_rdata, rdata);
    chk("burst_err", burst_err, m_err);
    if (eav) begin
      chk("araddr", araddr, oi ? i_araddr : d_araddr);
      chk("arlen", arlen, oi ? i_arlen : d_arlen);
      chk("arid", arid, oi ? 4'd0 : 4'd1);
      chk("arsize", arsize, oi ? 3'd2 : d_arsize);
      chk("arburst", arburst, 2'b01);
    end
  endtask

  // one clock: sample handshakes, play AXI slave, check at negedge
  task automatic step();
    bit av, ar_hs, r_hs, rl, ihs, dhs, ib, db;
    logic [7:0] cl;
    int cid;
    @(posedge clk);
    av    = arvalid;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    rl    = rlast;
    ihs   = i_arvalid && i_arready;
    dhs   = d_arvalid && d_arready;
    ib    = i_rvalid && i_rready;
    db    = d_rvalid && d_rready;
    cl    = arlen;
    cid   = int'(arid);
    #1;
    cyc++;
    if (av) av_edges++;
    if (ib) i_beats++;
    if (db) d_beats++;
    if (ihs) i_arvalid = 1'b0;
    if (dhs) d_arvalid = 1'b0;
    if (r_hs) begin
      s_beat++;
      s_gap = r_gap_en ? 2 : 0;
      if (rl) begin
        s_busy = 1'b0;
        n_last++;
        last_rlast_cyc = cyc;
      end
    end else if (s_gap > 0) begin
      s_gap--;
    end
    if (ar_hs) begin
      s_busy = 1'b1;
      s_beat = 0;
      s_len  = cl;
      s_gap  = 0;
      ar_log.push_back(cid);
      last_ar_cyc = cyc;
    end
    ar_wait = (av && !ar_hs) ? ar_wait + 1 : 0;
    arready = !s_busy && (ar_wait >= ar_stall);
    rvalid  = s_busy && (s_gap == 0);
    rdata   = 32'hA500_0000 + 32'(s_beat) + (32'(cyc) << 8);
    rid     = 4'(s_beat);
    rlast   = rvalid &&
              (s_beat == (bad_last >= 0 ? bad_last : int'(s_len)));
    if (i_rr_toggle) i_rready = !i_rready;
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_lasts(input int target, input int budget,
                            input string nm);
    int k;
    k = 0;
    while (n_last < target && k < budget) begin
      step();
      k++;
    end
    chk(nm, n_last, target);
  endtask

  task automatic clear_obs();
    i_beats  = 0;
    d_beats  = 0;
    n_last   = 0;
    av_edges = 0;
    ar_log.delete();
  endtask

  initial begin
    int d_last, ni, nd, k;
    rst = 1'b1;
    i_arvalid = 0; d_arvalid = 0;
    i_araddr = 0; i_arlen = 0;
    d_araddr = 0; d_arlen = 0; d_arsize = 0;
    i_rready = 1; d_rready = 1;
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0;
    step();
    step();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_i_arready", i_arready, 0);
    chk("rst_d_arready", d_arready, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_burst_err", burst_err, 0);
    rst = 1'b0;
    step();

    // 1: I-only burst of 8 beats
    clear_obs();
    i_araddr = 32'h1FC0_0000; i_arlen = 8'd7; i_arvalid = 1;
    step();
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, 0);
    chk("t1_araddr", araddr, 32'h1FC0_0000);
    chk("t1_arsize", arsize, 2);
    chk("t1_arlen", arlen, 7);
    wait_lasts(1, 60, "t1_done");
    step();
    chk("t1_i_beats", i_beats, 8);
    chk("t1_d_beats", d_beats, 0);
    chk("t1_err", burst_err, 0);
    chk("t1_idle_arvalid", arvalid, 0);

    // 2: tie straight from reset goes to D, then I after one bubble
    rst = 1; step(); rst = 0;
    clear_obs();
    i_araddr = 32'h0000_1000; i_arlen = 8'd1;
    d_araddr = 32'h8000_0040; d_arlen = 8'd2; d_arsize = 3'd3;
    i_arvalid = 1; d_arvalid = 1;
    step();
    chk("t2_first_arid", arid, 1);
    chk("t2_first_araddr", araddr, 32'h8000_0040);
    chk("t2_first_arsize", arsize, 3);
    wait_lasts(1, 60, "t2_d_done");
    d_last = last_rlast_cyc;
    wait_lasts(2, 60, "t2_i_done");
    chk("t2_n_ar", ar_log.size(), 2);
    if (ar_log.size() >= 2) begin
      chk("t2_order0", ar_log[0], 1);
      chk("t2_order1", ar_log[1], 0);
    end
    chk("t2_bubble", last_ar_cyc - d_last, 2);
    chk("t2_d_beats", d_beats, 3);
    chk("t2_i_beats", i_beats, 2);

    // 3: both sides keep requesting; grants must alternate
    step();
    clear_obs();
    i_arlen = 8'd1; d_arlen = 8'd0; d_arsize = 3'd2;
    ni = 1; nd = 1;
    i_arvalid = 1; d_arvalid = 1;
    k = 0;
    while (n_last < 6 && k < 200) begin
      step();
      k++;
      if (!i_arvalid && ni < 3) begin
        ni++; i_araddr = 32'h100 * ni; i_arvalid = 1;
      end
      if (!d_arvalid && nd < 3) begin
        nd++; d_araddr = 32'h9000_0000 + 32'h40 * nd; d_arvalid = 1;
      end
    end
    chk("t3_done", n_last, 6);
    chk("t3_n_ar", ar_log.size(), 6);
    for (int j = 0; j < 6 && j < ar_log.size(); j++)
      chk($sformatf("t3_grant%0d", j), ar_log[j], (j % 2 == 0) ? 1 : 0);

    // 4: AR stall, R gaps, toggling i_rready
    step();
    clear_obs();
    ar_stall = 5; r_gap_en = 1; i_rr_toggle = 1;
    i_araddr = 32'h2000_0100; i_arlen = 8'd3; i_arvalid = 1;
    wait_lasts(1, 100, "t4_done");
    step();
    chk("t4_av_edges", av_edges, 6);
    chk("t4_i_beats", i_beats, 4);
    chk("t4_d_beats", d_beats, 0);
    chk("t4_err", burst_err, 0);
    ar_stall = 0; r_gap_en = 0; i_rr_toggle = 0; i_rready = 1;
    step();

    // 5: early rlast sets a sticky error, cleared only by reset
    clear_obs();
    bad_last = 2;
    i_araddr = 32'h3000_0000; i_arlen = 8'd3; i_arvalid = 1;
    wait_lasts(1, 60, "t5_done");
    bad_last = -1;
    step();
    chk("t5_err_set", burst_err, 1);
    chk("t5_i_beats", i_beats, 3);
    d_araddr = 32'h3000_1000; d_arlen = 8'd1; d_arvalid = 1;
    wait_lasts(2, 60, "t5_d_done");
    step();
    chk("t5_err_sticky", burst_err, 1);
    rst = 1; step();
    chk("t5_err_rst", burst_err, 0);
    rst = 0; step();

    // 6a: D drops its request during the address phase
    clear_obs();
    ar_stall = 100;
    d_araddr = 32'h4000_0000; d_arlen = 8'd3; d_arvalid = 1;
    step();
    chk("t6_av", arvalid, 1);
    chk("t6_d_arready", d_arready, 0);
    step();
    d_arvalid = 0;
    step();
    chk("t6_abort_av", arvalid, 0);
    chk("t6_no_ar", ar_log.size(), 0);
    ar_stall = 0;
    i_araddr = 32'h5000_0000; i_arlen = 8'd7; i_arvalid = 1;
    step();
    chk("t6_regrant_av", arvalid, 1);
    chk("t6_regrant_arid", arid, 0);

    // 6b: reset in the middle of the I data phase
    k = 0;
    while (i_beats < 2 && k < 50) begin
      step();
      k++;
    end
    chk("t6_mid_beats", i_beats >= 2, 1);
    rst = 1;
    step();
    chk("t6_rst_i_rvalid", i_rvalid, 0);
    chk("t6_rst_rready", rready, 0);
    chk("t6_rst_arvalid", arvalid, 0);
    chk("t6_rst_d_rvalid", d_rvalid, 0);
    rst = 0;
    s_busy = 0; s_gap = 0;
    rvalid = 0; rlast = 0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
